uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Controller that sequences and shares the UART TX FIFO write port between two requesters:
//  (a) time-report frames "HH:MM:SS\r\n", built from the watch BCD digits, and (b) single-byte echo of received commands.
//  Sits between top_watch_stopwatch digit outputs / uart_cu and the UART_FIFO TX write side.
//  Frames are atomic; echo bytes are never interleaved inside a frame.
// PARAMETERS
//  DATA_WIDTH  8      TX byte width
//  SEND_CRLF   1      1: frame = 10 bytes (incl. 8'h0D,8'h0A); 0: frame = 8 bytes
//  SEP_CHAR    8'h3A  separator byte between HH, MM and SS
// PORTS
//  clk         in   1           system clock
//  rst         in   1           synchronous, active-high reset
//  tick_1s     in   1           1-cycle pulse; requests a frame when report_en=1
//  report_en   in   1           level; enables periodic reports
//  req_report  in   1           1-cycle pulse; on-demand frame request (ignores report_en)
//  echo_valid  in   1           1-cycle pulse; echo_data is valid this cycle
//  echo_data   in   DATA_WIDTH  received byte to echo
//  hour10,hour1,min10,min1,sec10,sec1  in  4 each  BCD time digits
//  tx_full     in   1           TX FIFO full
//  tx_wr       out  1           TX FIFO write strobe
//  tx_wdata    out  DATA_WIDTH  TX FIFO write data
//  busy        out  1           FSM not in IDLE
//  echo_drop   out  1           sticky: an echo byte was lost; cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE, rpt_pend=0, echo_pend=0, idx=0, snapshot=0, tx_wr=0, tx_wdata=0, busy=0, echo_drop=0.
//  Reset mid-frame aborts immediately; no further bytes; pending requests discarded.
//  Request capture (every cycle, any state):
//   - rpt_pend<=1 on (tick_1s&report_en)|req_report; extra requests while pending coalesce (1 deep).
//   - echo: 1-entry holding reg. If echo_valid and echo_pend=1 and the held byte is not consumed
//     this cycle -> new byte dropped, echo_drop<=1. If consumed this cycle -> new byte loaded.
//  FSM states: IDLE, LOAD, FRAME, ECHO.
//   - IDLE: echo_pend -> ECHO (echo wins over report); else rpt_pend -> LOAD; else stay.
//   - LOAD (1 cycle): snapshot all six digits, clear rpt_pend, idx<=0 -> FRAME.
//     Requests arriving in the same cycle re-set rpt_pend.
//   - FRAME: byte order h10,h1,SEP,m10,m1,SEP,s10,s1[,0D,0A]. Each byte is emitted on a cycle with
//     tx_full=0; idx++ on each write. After the last byte -> IDLE.
//   - ECHO: write echo byte when tx_full=0, clear echo_pend -> IDLE.
//  Digit->ASCII: 0..9 -> 8'h30+d; any value >9 -> 8'h3F ('?').
//  tx_wr = (state in {FRAME,ECHO}) & ~tx_full, combinational. tx_wdata is valid whenever tx_wr=1
//   and is 0 in IDLE/LOAD.
//  Backpressure: tx_full stalls indefinitely with no byte loss and no duplicates.
//  Latency, full FIFO never asserted: trigger at cycle N -> LOAD N+1 -> first byte N+2 -> last byte N+11
//   (CRLF) -> IDLE N+12. Echo: valid at N, IDLE -> ECHO N+1, write N+1... see test 2 for exact timing.
//  The snapshot guarantees a tear-free frame when digits roll over mid-frame.
//  busy = (state != IDLE).
// STRUCTURE
//  uart_pkg: state enum, ASCII constants (ASCII_0, ASCII_Q, CR, LF), FRAME_LEN derived from SEND_CRLF.
//  Sub-module bcd_to_ascii (combinational, 4b -> 8b with '?' on invalid digit), instantiated once
//   on the muxed snapshot digit.
//  Remaining logic (FSM, idx counter, pending flags, echo reg) is in uart_tx_sched.
// TESTING
//  1 time 12:34:56, tx_full=0, req_report pulse -> 10 writes 31 32 3A 33 34 3A 35 36 0D 0A on consecutive cycles; busy back to 0.
//  2 echo_valid with 8'h52 while IDLE -> exactly one write 8'h52, 1 cycle after the request.
//  3 tx_full held 1 for 5 cycles mid-frame (after byte 3) -> tx_wr=0 throughout; resume with byte 4; total 10 bytes, no repeats.
//  4 digits change 12:34:59 -> 12:35:00 during a frame -> frame still reads 12:34:59.
//  5 during a frame: echo 8'h41 then echo 8'h42 -> 41 sent after 0A; 42 dropped, echo_drop=1.
//    tick_1s x3 during the same frame -> exactly one follow-up frame.
//  6 rst asserted on byte 5 -> next cycle tx_wr=0, busy=0, no pending frame; hour1=4'hA -> byte 2 = 8'h3F.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX scheduler.
// Holds the FSM state enum, ASCII constants and frame-length helper.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FRAME,
    S_ECHO
  } state_t;

  typedef struct packed {
    logic [3:0] h10;
    logic [3:0] h1;
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } bcd_time_t;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_Q = 8'h3F;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic int unsigned frame_len(input bit crlf);
    return crlf ? 10 : 8;
  endfunction

endpackage

// File: rtl/uart_tx_sched_bcd.sv
// BCD digit to ASCII converter; invalid digits (>9) map to '?'.
// Ports: digit (4b BCD in), ascii (8b character out).
module bcd_to_ascii
  import uart_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] ascii
);

  always_comb begin
    if (digit <= 4'd9) ascii = ASCII_0 + {4'h0, digit};
    else ascii = ASCII_Q;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares the UART TX FIFO write port between time-report frames and echo bytes.
// Ports: clk/rst, tick_1s, report_en, req_report, echo_valid/echo_data,
//  BCD digits, tx_full in; tx_wr, tx_wdata, busy, echo_drop out.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter bit         SEND_CRLF  = 1'b1,
  parameter logic [7:0] SEP_CHAR   = 8'h3A
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1s,
  input  logic                  report_en,
  input  logic                  req_report,
  input  logic                  echo_valid,
  input  logic [DATA_WIDTH-1:0] echo_data,
  input  logic [3:0]            hour10,
  input  logic [3:0]            hour1,
  input  logic [3:0]            min10,
  input  logic [3:0]            min1,
  input  logic [3:0]            sec10,
  input  logic [3:0]            sec1,
  input  logic                  tx_full,
  output logic                  tx_wr,
  output logic [DATA_WIDTH-1:0] tx_wdata,
  output logic                  busy,
  output logic                  echo_drop
);

  localparam logic [3:0] LAST = 4'(frame_len(SEND_CRLF) - 1);

  state_t                state;
  state_t                state_nx;
  logic                  rpt_pend;
  logic                  echo_pend;
  logic [DATA_WIDTH-1:0] echo_reg;
  logic [3:0]            idx;
  bcd_time_t             snap;

  logic                  rpt_req;
  logic                  consume;
  logic [3:0]            digit;
  logic                  use_digit;
  logic [7:0]            fixed;
  logic [7:0]            digit_ascii;

  assign rpt_req = (tick_1s & report_en) | req_report;
  assign tx_wr   = ((state == S_FRAME) || (state == S_ECHO)) & ~tx_full;
  assign consume = (state == S_ECHO) & ~tx_full;
  assign busy    = (state != S_IDLE);

  // IDLE also looks at this cycle's requests so a trigger at N
  // reaches LOAD/ECHO at N+1.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (echo_pend | echo_valid) state_nx = S_ECHO;
        else if (rpt_pend | rpt_req) state_nx = S_LOAD;
      end
      S_LOAD: state_nx = S_FRAME;
      S_FRAME: begin
        if (tx_wr && (idx == LAST)) state_nx = S_IDLE;
      end
      S_ECHO: begin
        if (!tx_full) state_nx = S_IDLE;
      end
    endcase
  end

  always_comb begin
    digit     = 4'h0;
    use_digit = 1'b0;
    fixed     = 8'h00;
    case (idx)
      4'd0: begin digit = snap.h10; use_digit = 1'b1; end
      4'd1: begin digit = snap.h1;  use_digit = 1'b1; end
      4'd2: fixed = SEP_CHAR;
      4'd3: begin digit = snap.m10; use_digit = 1'b1; end
      4'd4: begin digit = snap.m1;  use_digit = 1'b1; end
      4'd5: fixed = SEP_CHAR;
      4'd6: begin digit = snap.s10; use_digit = 1'b1; end
      4'd7: begin digit = snap.s1;  use_digit = 1'b1; end
      4'd8: fixed = ASCII_CR;
      4'd9: fixed = ASCII_LF;
      default: fixed = 8'h00;
    endcase
  end

  bcd_to_ascii u_bcd (
    .digit (digit),
    .ascii (digit_ascii)
  );

  always_comb begin
    tx_wdata = '0;
    unique case (state)
      S_FRAME: tx_wdata = DATA_WIDTH'(use_digit ? digit_ascii : fixed);
      S_ECHO:  tx_wdata = echo_reg;
      default: tx_wdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rpt_pend  <= 1'b0;
      echo_pend <= 1'b0;
      echo_reg  <= '0;
      echo_drop <= 1'b0;
      idx       <= 4'd0;
      snap      <= '0;
    end else begin
      state <= state_nx;

      // LOAD consumes the pending request; a same-cycle one re-arms it.
      if (state == S_LOAD) rpt_pend <= rpt_req;
      else if (rpt_req) rpt_pend <= 1'b1;

      // Holding reg frees up in the cycle its byte is written.
      if (echo_valid) begin
        if (!echo_pend || consume) begin
          echo_reg  <= echo_data;
          echo_pend <= 1'b1;
        end else begin
          echo_drop <= 1'b1;
        end
      end else if (consume) begin
        echo_pend <= 1'b0;
      end

      if (state == S_LOAD) begin
        snap <= '{h10: hour10, h1: hour1, m10: min10,
                  m1: min1, s10: sec10, s1: sec1};
        idx  <= 4'd0;
      end else if ((state == S_FRAME) && tx_wr) begin
        idx <= idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: directed scenarios plus random traffic.
// Expected bytes are queued at stimulus time; a negedge monitor checks writes.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1s = 1'b0;
  logic       report_en = 1'b0;
  logic       req_report = 1'b0;
  logic       echo_valid = 1'b0;
  logic [7:0] echo_data = 8'h00;
  logic [3:0] hour10 = 0, hour1 = 0, min10 = 0;
  logic [3:0] min1 = 0, sec10 = 0, sec1 = 0;
  logic       tx_full = 1'b0;
  logic       tx_wr;
  logic [7:0] tx_wdata;
  logic       busy;
  logic       echo_drop;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wr_total = 0;
  logic [7:0] exp_q[$];
  int wr_cyc[$];

  uart_tx_sched #(
    .DATA_WIDTH (8),
    .SEND_CRLF  (1'b1),
    .SEP_CHAR   (8'h3A)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1s    (tick_1s),
    .report_en  (report_en),
    .req_report (req_report),
    .echo_valid (echo_valid),
    .echo_data  (echo_data),
    .hour10     (hour10),
    .hour1      (hour1),
    .min10      (min10),
    .min1       (min1),
    .sec10      (sec10),
    .sec1       (sec1),
    .tx_full    (tx_full),
    .tx_wr      (tx_wr),
    .tx_wdata   (tx_wdata),
    .busy       (busy),
    .echo_drop  (echo_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (tx_wr === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_total++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got %0h expected none (cycle %0d)",
                 tx_wdata, cyc);
      end else begin
        chk("tx_byte", {24'h0, tx_wdata}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [7:0] asc(input logic [3:0] d);
    return (d <= 4'd9) ? 8'h30 + {4'h0, d} : 8'h3F;
  endfunction

  task automatic push_frame();
    exp_q.push_back(asc(hour10));
    exp_q.push_back(asc(hour1));
    exp_q.push_back(8'h3A);
    exp_q.push_back(asc(min10));
    exp_q.push_back(asc(min1));
    exp_q.push_back(8'h3A);
    exp_q.push_back(asc(sec10));
    exp_q.push_back(asc(sec1));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour10 = 4'(h / 10); hour1 = 4'(h % 10);
    min10  = 4'(m / 10); min1  = 4'(m % 10);
    sec10  = 4'(s / 10); sec1  = 4'(s % 10);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm, input bit rnd_full);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < 400) begin
      if (rnd_full) tx_full = ($urandom_range(0, 2) == 0);
      tick();
      n++;
      if (busy == 1'b0 && exp_q.size() == 0) done = 1;
    end
    tx_full = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d bytes left expected 0",
               nm, exp_q.size());
      exp_q.delete();
    end
    repeat (4) tick();
  endtask

  initial begin
    int n0;
    int left;
    // reset
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_tx_wr", {31'h0, tx_wr}, 0);
    chk("rst_wdata", {24'h0, tx_wdata}, 0);
    chk("rst_drop", {31'h0, echo_drop}, 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // 1: basic frame and latency
    set_time(12, 34, 56);
    wr_cyc.delete();
    push_frame();
    req_report = 1'b1;
    n0 = cyc;
    tick();
    req_report = 1'b0;
    wait_idle("t1", 0);
    chk("t1_count", wr_cyc.size(), 10);
    if (wr_cyc.size() == 10) begin
      chk("t1_first_cyc", wr_cyc[0], n0 + 2);
      chk("t1_last_cyc", wr_cyc[9], n0 + 11);
    end
    chk("t1_busy_end", {31'h0, busy}, 0);

    // 2: echo while idle
    wr_cyc.delete();
    exp_q.push_back(8'h52);
    echo_data = 8'h52;
    echo_valid = 1'b1;
    n0 = cyc;
    tick();
    echo_valid = 1'b0;
    wait_idle("t2", 0);
    chk("t2_count", wr_cyc.size(), 1);
    if (wr_cyc.size() == 1) chk("t2_cyc", wr_cyc[0], n0 + 1);

    // 3: backpressure after byte 3
    wr_cyc.delete();
    n0 = wr_total;
    push_frame();
    req_report = 1'b1;
    tick();
    req_report = 1'b0;
    for (int i = 0; i < 20 && wr_total < n0 + 3; i++) tick();
    tx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_wr", {31'h0, tx_wr}, 0);
      tick();
    end
    tx_full = 1'b0;
    wait_idle("t3", 0);
    chk("t3_count", wr_total - n0, 10);

    // 4: digits roll over after snapshot
    set_time(12, 34, 59);
    push_frame();
    req_report = 1'b1;
    tick();
    req_report = 1'b0;
    tick();
    set_time(12, 35, 0);
    wait_idle("t4", 0);

    // 5: echoes and ticks during a frame
    set_time(7, 8, 9);
    report_en = 1'b1;
    n0 = wr_total;
    push_frame();
    exp_q.push_back(8'h41);
    push_frame();
    req_report = 1'b1;
    tick();
    req_report = 1'b0;
    repeat (3) tick();
    echo_data = 8'h41; echo_valid = 1'b1; tick();
    echo_valid = 1'b0; tick_1s = 1'b1; tick();
    tick_1s = 1'b0;
    echo_data = 8'h42; echo_valid = 1'b1; tick();
    echo_valid = 1'b0; tick_1s = 1'b1; tick();
    tick();
    tick_1s = 1'b0;
    report_en = 1'b0;
    wait_idle("t5", 0);
    chk("t5_count", wr_total - n0, 21);
    chk("t5_drop", {31'h0, echo_drop}, 1);

    // 6: reset mid-frame, invalid digit
    hour10 = 4'd1; hour1 = 4'hA;
    min10 = 4'd3; min1 = 4'd4; sec10 = 4'd5; sec1 = 4'd6;
    n0 = wr_total;
    push_frame();
    repeat (5) void'(exp_q.pop_back());
    req_report = 1'b1;
    tick();
    req_report = 1'b0;
    for (int i = 0; i < 20 && wr_total < n0 + 4; i++) tick();
    req_report = 1'b1;
    rst = 1'b1;
    tick();
    req_report = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_wr_after_rst", {31'h0, tx_wr}, 0);
    chk("t6_busy_after_rst", {31'h0, busy}, 0);
    chk("t6_drop_cleared", {31'h0, echo_drop}, 0);
    repeat (15) tick();
    chk("t6_bytes", wr_total - n0, 5);
    chk("t6_q_empty", exp_q.size(), 0);

    // random: one request at a time under random backpressure
    for (int k = 0; k < 40; k++) begin
      int kind;
      hour10 = 4'($urandom_range(0, 11));
      hour1  = 4'($urandom_range(0, 11));
      min10  = 4'($urandom_range(0, 11));
      min1   = 4'($urandom_range(0, 11));
      sec10  = 4'($urandom_range(0, 11));
      sec1   = 4'($urandom_range(0, 11));
      kind = int'($urandom_range(0, 3));
      left = wr_total;
      case (kind)
        0: begin
          push_frame();
          req_report = 1'b1;
        end
        1: begin
          report_en = 1'($urandom_range(0, 1));
          if (report_en) push_frame();
          tick_1s = 1'b1;
        end
        default: begin
          echo_data = 8'($urandom);
          exp_q.push_back(echo_data);
          echo_valid = 1'b1;
        end
      endcase
      tick();
      req_report = 1'b0;
      tick_1s = 1'b0;
      echo_valid = 1'b0;
      report_en = 1'b0;
      wait_idle("rand", 1);
      chk("rand_drop", {31'h0, echo_drop}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
